// File: rtl/flip_sweep_pkg.sv
// ============================================================================
// Module   : flip_sweep_pkg
// Brief    : Shared state encoding and constant helpers for the flip sweeper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package flip_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_FLIP    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam int C_REP_W = 8;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flip_sweep_sequencer_dwell.sv
// ============================================================================
// Module   : dwell_counter
// Brief    : Loadable down-counter with zero flag, shared by SETTLE and CAPTURE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dwell_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/flip_sweep_sequencer.sv
// ============================================================================
// Module   : flip_sweep_sequencer
// Brief    : Walks a single-bit flip across a base pattern with settle/trigger
//            dwells; optional per-index repeats under FLIP_SWEEP_REPEAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module flip_sweep_sequencer
  import flip_sweep_pkg::*;
#(
  parameter  int NUM_INS    = 8,
  parameter  int SETTLE_CYC = 4,
  parameter  int TRIG_CYC   = 16,
  localparam int IDX_W      = (clog2(NUM_INS) > 1) ? clog2(NUM_INS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_INS-1:0] base_pattern,
  input  logic [IDX_W-1:0]   last_idx,
`ifdef FLIP_SWEEP_REPEAT_EN
  input  logic [C_REP_W-1:0] rep_count,
  output logic [C_REP_W-1:0] rep_index,
`endif
  output logic [NUM_INS-1:0] dut_inputs,
  output logic [IDX_W-1:0]   flip_index,
  output logic               trigger,
  output logic               busy,
  output logic               done
);

  localparam int                c_cnt_w       = max2(1, clog2(max2(SETTLE_CYC, TRIG_CYC)));
  localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_trig_load   = c_cnt_w'(TRIG_CYC - 1);
  localparam bit                c_need_clamp  = (NUM_INS < (1 << IDX_W));
  localparam logic [IDX_W-1:0]  c_max_idx     = IDX_W'(NUM_INS - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [NUM_INS-1:0]   r_pattern;
  logic [NUM_INS-1:0]   r_dut_inputs;
  logic [NUM_INS-1:0]   w_flip_mask;
  logic [IDX_W-1:0]     r_last_idx;
  logic [IDX_W-1:0]     r_index;
  logic [IDX_W-1:0]     w_last_clamped;
  logic                 w_latch;
  logic                 w_load_out;
  logic                 w_flip_out;
  logic                 w_idx_inc;
  logic                 w_cnt_load;
  logic                 w_cnt_dec;
  logic [c_cnt_w-1:0]   w_cnt_val;
  logic                 w_cnt_zero;

  generate
    if (c_need_clamp) begin : g_clamp
      assign w_last_clamped = (last_idx > c_max_idx) ? c_max_idx : last_idx;
    end else begin : g_no_clamp
      assign w_last_clamped = last_idx;
    end
  endgenerate

`ifdef FLIP_SWEEP_REPEAT_EN
  logic [C_REP_W-1:0] r_rep_last;
  logic [C_REP_W-1:0] r_rep_index;
  logic               w_rep_inc;
  logic               w_rep_clr;

  // A requested count of zero still runs one pass per index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rep_last  <= '0;
      r_rep_index <= '0;
    end else if (w_latch) begin
      r_rep_last  <= (rep_count == '0) ? '0 : rep_count - 8'd1;
      r_rep_index <= '0;
    end else if (w_rep_clr) begin
      r_rep_index <= '0;
    end else if (w_rep_inc) begin
      r_rep_index <= r_rep_index + 8'd1;
    end
  end

  assign rep_index = r_rep_index;
`endif

  dwell_counter #(
    .CNT_W (c_cnt_w)
  ) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_load_out   = 1'b0;
    w_flip_out   = 1'b0;
    w_idx_inc    = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_cnt_val    = '0;
`ifdef FLIP_SWEEP_REPEAT_EN
    w_rep_inc    = 1'b0;
    w_rep_clr    = 1'b0;
`endif
    if ((r_state != ST_IDLE) && abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_latch      = 1'b1;
            w_next_state = ST_LOAD;
          end
        end
        ST_LOAD: begin
          w_load_out   = 1'b1;
          w_cnt_load   = 1'b1;
          w_cnt_val    = c_settle_load;
          w_next_state = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_cnt_zero) begin
            w_next_state = ST_FLIP;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        ST_FLIP: begin
          w_flip_out   = 1'b1;
          w_cnt_load   = 1'b1;
          w_cnt_val    = c_trig_load;
          w_next_state = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (w_cnt_zero) begin
`ifdef FLIP_SWEEP_REPEAT_EN
            if (r_rep_index < r_rep_last) begin
              w_rep_inc    = 1'b1;
              w_next_state = ST_LOAD;
            end else begin
              w_next_state = ST_NEXT;
            end
`else
            w_next_state = ST_NEXT;
`endif
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        ST_NEXT: begin
`ifdef FLIP_SWEEP_REPEAT_EN
          w_rep_clr = 1'b1;
`endif
          if (r_index == r_last_idx) begin
            w_next_state = ST_DONE;
          end else begin
            w_idx_inc    = 1'b1;
            w_next_state = ST_LOAD;
          end
        end
        ST_DONE: begin
          w_next_state = ST_IDLE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_flip_mask          = '0;
    w_flip_mask[r_index] = 1'b1;
  end

  // dut_inputs already carries the pattern when FLIP runs, so XOR flips one bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pattern    <= '0;
      r_last_idx   <= '0;
      r_index      <= '0;
      r_dut_inputs <= '0;
    end else begin
      if (w_latch) begin
        r_pattern  <= base_pattern;
        r_last_idx <= w_last_clamped;
        r_index    <= '0;
      end else if (w_idx_inc) begin
        r_index <= r_index + 1'b1;
      end
      if (w_load_out) begin
        r_dut_inputs <= r_pattern;
      end else if (w_flip_out) begin
        r_dut_inputs <= r_pattern ^ w_flip_mask;
      end
    end
  end

  assign dut_inputs = r_dut_inputs;
  assign flip_index = r_index;
  assign trigger    = (r_state == ST_CAPTURE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_flip_sweep_sequencer.sv
// ============================================================================
// Module   : tb_flip_sweep_sequencer
// Brief    : Randomized self-checking bench with a cycle-offset reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_flip_sweep_sequencer;

  localparam int NUM_INS    = 8;
  localparam int SETTLE_CYC = 4;
  localparam int TRIG_CYC   = 16;
  localparam int IDX_W      = 3;
  localparam int PERIOD     = SETTLE_CYC + TRIG_CYC + 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [NUM_INS-1:0] base_pattern = '0;
  logic [IDX_W-1:0]   last_idx = '0;
  logic [NUM_INS-1:0] dut_inputs;
  logic [IDX_W-1:0]   flip_index;
  logic               trigger;
  logic               busy;
  logic               done;
`ifdef FLIP_SWEEP_REPEAT_EN
  logic [7:0]         rep_count = 8'd1;
  logic [7:0]         rep_index;
`endif

  int                 checks   = 0;
  int                 failures = 0;
  logic [NUM_INS-1:0] m_dut    = '0;

  always #5 clk = ~clk;

  flip_sweep_sequencer #(
    .NUM_INS    (NUM_INS),
    .SETTLE_CYC (SETTLE_CYC),
    .TRIG_CYC   (TRIG_CYC)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .base_pattern (base_pattern),
    .last_idx     (last_idx),
`ifdef FLIP_SWEEP_REPEAT_EN
    .rep_count    (rep_count),
    .rep_index    (rep_index),
`endif
    .dut_inputs   (dut_inputs),
    .flip_index   (flip_index),
    .trigger      (trigger),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input logic [7:0] e_dut, input int e_idx,
                           input bit e_trig, input bit e_busy, input bit e_done);
    check("dut_inputs", 32'(dut_inputs), 32'(e_dut));
    if (e_idx >= 0) check("flip_index", 32'(flip_index), e_idx);
    check("trigger", 32'(trigger), 32'(e_trig));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
`ifdef FLIP_SWEEP_REPEAT_EN
    check("rep_index", 32'(rep_index), 32'd0);
`endif
  endtask

  // Cycle k of a sweep (k=1 is the first cycle after start is taken) maps to
  // index (k-1)/PERIOD and offset (k-1)%PERIOD: 0 load, 1..S settle, S+1 flip,
  // S+2..S+T+1 capture, S+T+2 next; the done pulse lands on k=(last+1)*PERIOD+1.
  task automatic run_sweep(input logic [7:0] pat, input logic [IDX_W-1:0] last,
                           input int abort_k, input int reset_k, input bit hold);
    int eff_last;
    int total;
    int idx;
    int o;
    @(negedge clk);
    check_all(m_dut, -1, 1'b0, 1'b0, 1'b0);
    start        = 1'b1;
    base_pattern = pat;
    last_idx     = last;
    eff_last     = (int'(last) >= NUM_INS) ? NUM_INS - 1 : int'(last);
    total        = (eff_last + 1) * PERIOD + 1;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == total) begin
        check_all(m_dut, eff_last, 1'b0, 1'b1, 1'b1);
      end else begin
        idx = (k - 1) / PERIOD;
        o   = (k - 1) % PERIOD;
        if (o >= 1 && o <= SETTLE_CYC + 1) m_dut = pat;
        else if (o >= SETTLE_CYC + 2) m_dut = pat ^ (8'h01 << idx);
        check_all(m_dut, idx, (o >= SETTLE_CYC + 2) && (o <= SETTLE_CYC + TRIG_CYC + 1),
                  1'b1, 1'b0);
      end
      start        = (k == total) ? hold : 1'($urandom);
      base_pattern = 8'($urandom);
      last_idx     = IDX_W'($urandom);
      if (k == abort_k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_all(m_dut, -1, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (k == reset_k) begin
        start = 1'b0;
        #2 reset = 1'b0;
        #1 m_dut = '0;
        check_all(m_dut, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
    end
  endtask

  task automatic idle_cycles(input int n, input bit rand_abort);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all(m_dut, -1, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      abort = rand_abort ? 1'($urandom) : 1'b0;
    end
    abort = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 check_all(8'h00, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    run_sweep(8'h00, 3'd2, 0, 0, 1'b0);
    run_sweep(8'h5A, 3'(15), 0, 0, 1'b0);
    run_sweep(8'hC3, 3'd3, PERIOD + SETTLE_CYC + 7, 0, 1'b0);
    idle_cycles(4, 1'b0);
    idle_cycles(6, 1'b1);
    run_sweep(8'h0F, 3'd4, 0, 3, 1'b0);
    idle_cycles(3, 1'b0);
    run_sweep(8'h96, 3'd1, 0, 0, 1'b1);
    run_sweep(8'h3C, 3'd0, 0, 0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run_sweep(8'($urandom), IDX_W'($urandom), 0, 0, 1'($urandom));
    end
    idle_cycles(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flip_sweep_sequencer.md
FLIP_SWEEP_SEQUENCER -- requirements
Module: flip_sweep_sequencer

Interface
REQ-001 SHALL have parameter NUM_INS, default 8: width of the DUT input vector driven.
REQ-002 SHALL have parameter SETTLE_CYC, default 4: cycles the base pattern is held before each flip (min 1).
REQ-003 SHALL have parameter TRIG_CYC, default 16: cycles trigger stays high per flip (min 1).
REQ-004 SHALL have derived localparam IDX_W = max(1, clog2(NUM_INS)).
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: begins a sweep when sampled high in IDLE.
REQ-008 SHALL have port abort, input, 1: terminates a sweep.
REQ-009 SHALL have port base_pattern, input, NUM_INS: the unflipped input vector.
REQ-010 SHALL have port last_idx, input, IDX_W: highest bit index to sweep.
REQ-011 SHALL have port dut_inputs, output, NUM_INS: registered vector applied to the DUT.
REQ-012 SHALL have port flip_index, output, IDX_W: bit currently being flipped.
REQ-013 SHALL have ports trigger, busy and done, each output, 1 bit: scope trigger, sweep-in-progress flag and end-of-sweep pulse.

Function
REQ-014 SHALL implement the states IDLE, LOAD, SETTLE, FLIP, CAPTURE, NEXT and DONE.
REQ-015 SHALL, in IDLE with start=1, latch base_pattern and last_idx into internal registers, clear the index to 0 and go to LOAD; start SHALL be ignored in every other state.
REQ-016 SHALL clamp a latched last_idx >= NUM_INS to NUM_INS-1.
REQ-017 SHALL, in LOAD, register dut_inputs <= latched pattern for one cycle, then go to SETTLE.
REQ-018 SHALL stay in SETTLE for exactly SETTLE_CYC cycles, then go to FLIP.
REQ-019 SHALL, in FLIP, register dut_inputs[index] <= ~pattern[index] (one cycle), then go to CAPTURE.
REQ-020 SHALL assert trigger from the first cycle dut_inputs shows the flipped value, for exactly TRIG_CYC cycles (the CAPTURE dwell).
REQ-021 SHALL, in NEXT, go to DONE if index == latched last_idx, otherwise increment the index and go to LOAD.
REQ-022 SHALL, in DONE, pulse done high for exactly one cycle and return to IDLE.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL drive flip_index equal to the internal index register.
REQ-025 SHALL, on abort=1 in any non-IDLE state, go to IDLE on the next edge with trigger=0, done=0 and dut_inputs held; abort SHALL have priority over all other transitions.
REQ-026 SHALL take no action and not return an error when abort=1 in IDLE.
REQ-027 SHALL take exactly (last_idx+1) x (SETTLE_CYC+TRIG_CYC+3) + 1 cycles per sweep from start to the done pulse.

Reset
REQ-028 SHALL, when reset=0, asynchronously set state=IDLE, index=0, dut_inputs=0, trigger=0, busy=0 and done=0.
REQ-029 SHALL discard the sweep in progress when reset is asserted mid-sweep and require a new start afterwards.

Configuration
REQ-030 SHALL, with macro FLIP_SWEEP_REPEAT_EN defined, add input rep_count[7:0], latched at start, and repeat LOAD..CAPTURE rep_count times per index before NEXT; a latched rep_count of 0 SHALL act as 1.
REQ-031 SHALL also, with FLIP_SWEEP_REPEAT_EN defined, add output rep_index[7:0], reset value 0, counting repeats within the current index.
REQ-032 SHALL, without FLIP_SWEEP_REPEAT_EN, omit rep_count and rep_index and perform exactly one pass per index.

Structure
REQ-033 SHALL place the state enum typedef and the clog2 constant function in shared package flip_sweep_pkg.
REQ-034 SHALL implement the SETTLE/CAPTURE dwells with one sub-module, dwell_counter (loadable down-counter with a zero flag), reused for both dwells.

Verification
REQ-035 SHALL cover: NUM_INS=8, base=8'h00, last_idx=2, start -> dut_inputs 01, 02, 04 in turn; 3 trigger pulses of 16 cycles; done after 3x23+1=70 cycles.
REQ-036 SHALL cover: last_idx=15 with NUM_INS=8 -> clamp to 7; 8 flips; final flipped value base^8'h80.
REQ-037 SHALL cover: abort asserted on the 5th CAPTURE cycle of index 1 -> IDLE next edge; trigger low; no done; dut_inputs unchanged.
REQ-038 SHALL cover: reset pulled low during SETTLE -> all outputs 0 immediately, without waiting for a clk edge.
REQ-039 SHALL cover: start held high throughout the sweep -> a new sweep begins only in the cycle after the done pulse.
REQ-040 SHALL cover, with FLIP_SWEEP_REPEAT_EN and rep_count=3, last_idx=1: 6 trigger pulses; rep_index 0,1,2 per index; rep_count=0 gives 2 pulses.
